// File: rtl/iurt_wb_initiator_if.sv
// rtl/iurt_wb_initiator_if.sv - Wishbone bus between the IURT host-side initiator and the controller slave port
interface iurt_wb_initiator_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic        adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/iurt_wb_initiator.sv
// rtl/iurt_wb_initiator.sv - Wishbone initiator polling the IURT controller and streaming bytes both ways
// Optional ack timeout / sticky bus_err enabled by defining IURT_WB_TIMEOUT_EN.
module iurt_wb_initiator #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  iurt_wb_initiator_if.master        wb,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [7:0]                 tx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [7:0]                 rx_data,
  output logic                       bus_err
);

  localparam int unsigned PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAT,
    S_DECIDE,
    S_WR,
    S_RD
  } state_t;

  state_t        state_q;
  logic          cyc_q;
  logic          we_q;
  logic          adr_q;
  logic [7:0]    wdat_q;
  logic [1:0]    status_q;
  logic          tx_ready_q;
  logic          rx_valid_q;
  logic [7:0]    rx_data_q;
  logic [PW-1:0] poll_q;
  logic          unused_dat_i;

`ifdef IURT_WB_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  logic [TW-1:0] tmo_q;
  logic          bus_err_q;
  assign bus_err = bus_err_q;
`else
  localparam int unsigned unused_ack_timeout = ACK_TIMEOUT;
  assign bus_err = 1'b0;
`endif

  // Only the status flags and the DATA byte/valid bits carry meaning.
  assign unused_dat_i = &{1'b0, wb.dat_i[31:9]};

  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = cyc_q;
  assign wb.we_o  = we_q;
  assign wb.adr_o = adr_q;
  assign wb.dat_o = {24'h0, wdat_q};
  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 1'b0;
      wdat_q     <= 8'h00;
      status_q   <= 2'b00;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      poll_q     <= '0;
`ifdef IURT_WB_TIMEOUT_EN
      tmo_q      <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else if (ce) begin
      tx_ready_q <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (tx_valid || poll_q == POLL_LAST) begin
            poll_q  <= '0;
            state_q <= S_STAT;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= 1'b1;
          end else begin
            poll_q <= poll_q + 1'b1;
          end
        end
        S_STAT: begin
          if (wb.ack_i) begin
            cyc_q    <= 1'b0;
            status_q <= wb.dat_i[1:0];
            state_q  <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          // Draining rx wins over tx so the controller's receive side never backs up.
          if (status_q[1] && !rx_valid_q) begin
            state_q <= S_RD;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= 1'b0;
          end else if (status_q[0] && tx_valid) begin
            state_q <= S_WR;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= 1'b0;
            wdat_q  <= tx_data;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WR: begin
          if (wb.ack_i) begin
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            tx_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_RD: begin
          if (wb.ack_i) begin
            cyc_q   <= 1'b0;
            state_q <= S_IDLE;
            if (wb.dat_i[8]) begin
              rx_data_q  <= wb.dat_i[7:0];
              rx_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
`ifdef IURT_WB_TIMEOUT_EN
      // Overrides the case above: an unanswered cycle is abandoned without host side effects.
      if (cyc_q && !wb.ack_i) begin
        if (tmo_q == TMO_LAST) begin
          tmo_q     <= '0;
          cyc_q     <= 1'b0;
          we_q      <= 1'b0;
          bus_err_q <= 1'b1;
          state_q   <= S_IDLE;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_iurt_wb_initiator.sv
// tb/tb_iurt_wb_initiator.sv - randomized bench with a queue-based IURT slave and host model
module tb_iurt_wb_initiator;
  localparam int unsigned POLL = 6;
  localparam int unsigned TMO  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       bus_err;

  iurt_wb_initiator_if bus ();

  iurt_wb_initiator #(.POLL_INTERVAL(POLL), .ACK_TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .wb       (bus),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] tx_q[$];
  logic [7:0] rx_src[$];
  logic [7:0] exp_rx[$];

  logic        cyc_p, we_p, adr_p, txr_p, rxv_p;
  logic [31:0] dat_p;
  logic [7:0]  rxd_p;
  logic        dec_pend;
  logic [1:0]  dec_stat;
  int          ack_dly;
  int          n_wr, n_rx;
  bit          refill;
  bit          hold_wr;

  task automatic snap_prev();
    cyc_p = bus.cyc_o;
    we_p  = bus.we_o;
    adr_p = bus.adr_o;
    dat_p = bus.dat_o;
    txr_p = tx_ready;
    rxv_p = rx_valid;
    rxd_p = rx_data;
  endtask

  // One negedge step: judge the posedge just passed, then drive the next inputs.
  task automatic tick();
    logic       done;
    logic [1:0] kind_o, kind_e;
    @(negedge clk);
    done = ce && bus.ack_i && cyc_p;

    if (ce && dec_pend) begin
      kind_e = (dec_stat[1] && !rxv_p) ? 2'd1 : ((dec_stat[0] && tx_valid) ? 2'd2 : 2'd0);
      kind_o = !bus.cyc_o ? 2'd0 : (bus.we_o ? 2'd2 : (bus.adr_o ? 2'd3 : 2'd1));
      check_eq("decide", kind_o, kind_e);
      dec_pend = 1'b0;
    end
    if (cyc_p && bus.cyc_o && !done) begin
      check_eq("bus_hold", {bus.we_o, bus.adr_o, bus.dat_o}, {we_p, adr_p, dat_p});
    end
    if (cyc_p && !we_p && !adr_p) begin
      check_eq("no_rd_while_rx", rxv_p, 1'b0);
    end
    if (ce && (tx_ready != txr_p || (done && we_p))) begin
      check_eq("tx_ready_pulse", tx_ready, done && we_p);
    end
    if (done && we_p) begin
      check_eq("wr_has_tx", tx_q.size() != 0, 1'b1);
      if (tx_q.size() != 0) begin
        check_eq("wr_data", dat_p, {24'h0, tx_q[0]});
        void'(tx_q.pop_front());
      end
      n_wr++;
    end
    if (done && !we_p && adr_p) begin
      dec_pend = 1'b1;
      dec_stat = bus.dat_i[1:0];
    end
    if (done && !we_p && !adr_p) begin
      check_eq("rx_valid_set", rx_valid, bus.dat_i[8]);
      if (bus.dat_i[8]) begin
        check_eq("rx_data_set", rx_data, bus.dat_i[7:0]);
        exp_rx.push_back(bus.dat_i[7:0]);
      end
    end
    if (ce && rxv_p && rx_ready) begin
      check_eq("rx_pending", exp_rx.size(), 1);
      if (exp_rx.size() != 0) begin
        check_eq("rx_data", rxd_p, exp_rx.pop_front());
      end
      check_eq("rx_clear", rx_valid, 1'b0);
      n_rx++;
    end

    if (done) begin
      bus.ack_i = 1'b0;
      bus.dat_i = $urandom;
    end else if (bus.cyc_o && bus.stb_o && !bus.ack_i && !(hold_wr && bus.we_o)) begin
      if (ack_dly > 0) begin
        ack_dly--;
      end else begin
        bus.ack_i = 1'b1;
        if (bus.we_o) begin
          bus.dat_i = $urandom;
        end else if (bus.adr_o) begin
          bus.dat_i = {30'h0, rx_src.size() != 0, $urandom_range(0, 3) != 0};
        end else if (rx_src.size() != 0 && $urandom_range(0, 7) != 0) begin
          bus.dat_i = {23'h0, 1'b1, rx_src.pop_front()};
        end else begin
          bus.dat_i = {23'h0, 1'b0, 8'($urandom)};
        end
      end
    end
    if (!bus.cyc_o) ack_dly = $urandom_range(0, 3);

    if (refill && $urandom_range(0, 39) == 0 && tx_q.size() < 8) tx_q.push_back(8'($urandom));
    if (refill && $urandom_range(0, 39) == 0 && rx_src.size() < 8) rx_src.push_back(8'($urandom));
    ce       = $urandom_range(0, 9) != 0;
    rx_ready = $urandom_range(0, 2) == 0;
    tx_valid = tx_q.size() != 0;
    if (tx_q.size() != 0) tx_data = tx_q[0];
    snap_prev();
  endtask

  initial begin
    int n;
    bit saw_txr;
    rst = 1'b1; ce = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    bus.ack_i = 1'b0; bus.dat_i = 32'h0;
    dec_pend = 1'b0; dec_stat = 2'b00; ack_dly = 0; n_wr = 0; n_rx = 0;
    refill = 1'b0; hold_wr = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_bus", {bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o}, 4'b0000);
    check_eq("rst_dat_o", bus.dat_o, 32'h0);
    check_eq("rst_host", {tx_ready, rx_valid, bus_err}, 3'b000);
    check_eq("rst_rx_data", rx_data, 8'h00);

    rst = 1'b0;
    n = 0;
    while (!bus.cyc_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("first_poll_edge", n, POLL);
    check_eq("first_poll_kind", {bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o}, 4'b1101);

    tx_q.push_back(8'h55);
    rx_src.push_back(8'h42);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    refill   = 1'b1;
    snap_prev();
    repeat (4000) tick();
    check_eq("tx_progress", n_wr > 10, 1'b1);
    check_eq("rx_progress", n_rx > 10, 1'b1);
    check_eq("bus_err_idle", bus_err, 1'b0);

    refill  = 1'b0;
    hold_wr = 1'b1;
    if (tx_q.size() == 0) tx_q.push_back(8'hA5);
    n = 0;
    while (!(bus.cyc_o && bus.we_o) && n < 600) begin
      tick();
      n++;
    end
    check_eq("reach_wr", bus.cyc_o && bus.we_o, 1'b1);
    ce = 1'b1;
    bus.ack_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_wr", {bus.cyc_o, bus.stb_o, tx_ready}, 3'b000);
    rst = 1'b0;
    saw_txr = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (tx_ready) saw_txr = 1'b1;
    end
    check_eq("no_tx_ready_after_rst", saw_txr, 1'b0);

`ifdef IURT_WB_TIMEOUT_EN
    tx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!bus.cyc_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.cyc_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_len", n, TMO);
    check_eq("tmo_bus_err", bus_err, 1'b1);
    check_eq("tmo_no_host", {tx_ready, rx_valid}, 2'b00);
`else
    check_eq("bus_err_tied", bus_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
